clk_div_multi: RTL
==================

Name: clk_div_multi

Overview:
Multi-channel programmable clock/strobe divider for fabric-generated slow clocks (LED blink, UART/SPI bit strobes). Each of NCH channels has a runtime-programmable period and high time. Updates go through a valid/ready config port and are applied glitch-free at the period boundary. Outputs are registered enables/slow clocks plus a one-cycle wrap tick per channel.

Parameters:
NCH, 4, number of independent channels (1..16)
DIV_W, 24, width of period and high-time fields
RST_DIV, 0, period loaded into every channel at reset (0 = channel stopped)
RST_HI, 0, high time loaded at reset (0 = 50 %)

Ports:
clk_in  input  1  system clock
nrst  input  1  reset: asynchronous, active-low
en  input  NCH  per-channel run enable
cfg_valid  input  1  config request
cfg_ready  output  1  config accepted when valid&&ready
cfg_ch  input  max(1,$clog2(NCH))  target channel
cfg_div  input  DIV_W  new period P in clk_in cycles
cfg_hi  input  DIV_W  new high time H
clk_out  output  NCH  divided outputs, registered
tick  output  NCH  one-cycle pulse on last cycle of each period

Behaviour:
- Reset (async, nrst=0): cnt=0, clk_out=0, tick=0, pending=0, active P=RST_DIV, active H=RST_HI, for all channels.
- Effective values: P<2 -> channel stopped (clk_out=0, tick=0, cnt=0). H=0 -> H_eff=P>>1 (odd P: low phase one cycle longer). H>=P -> H_eff=P-1.
- Running (en[i]=1, P>=2): cnt counts 0..P-1 and wraps to 0. Registered: clk_out[i]=1 while cnt<H_eff. tick[i]=1 in the cycle with cnt==P-1.
- Start latency: first rising edge with en[i]=1 gives cnt=0 and clk_out=1 on that edge's output. en[i]=0 -> next edge gives cnt=0, clk_out=0, tick=0. There is no partial period on restart.
- Config handshake: cfg_ready = !pending[cfg_ch] (combinational on cfg_ch). Out-of-range cfg_ch -> cfg_ready=1, and the write is dropped. On accept, cfg_div/cfg_hi go to the shadow register and pending is set.
- Apply: pending shadow moves to active on the wrap edge (cnt==P-1), or on the next edge if the channel is stopped or en[i]=0. pending then clears. Ready returns 1 on the following cycle.
- A new period starts with new values, so no runt pulse and no glitch.
- Simultaneous accept and wrap on the same channel: shadow is captured this edge and applied at the next wrap, never in the same edge.
- Arithmetic: compares are unsigned at DIV_W. cnt is DIV_W wide. No multiplies or divides in the datapath.
- Reset mid-period: immediate return to reset values. Pending writes are lost.

Optional Feature:
CLKDIV_SYNC_EN
- Defined: adds input sync_in (1 bit). A sync_in=1 cycle forces cnt=0 on all running channels at the next edge, which gives phase-aligned rising edges. Pending shadows are applied at that edge. tick is not asserted for the truncated period.
- Undefined: port absent. Channels free-run independently.

Decomposition:
- clk_div_pkg holds: DIV_W default, the chan_cfg_t struct {div, hi}, and a function eff_hi(div, hi) implementing the clamp/50 % rule.
- One sub-module, clk_div_chan: counter, shadow, pending flag and output regs for one channel. It is instantiated NCH times by a generate loop. The top level holds only the cfg decode and ready mux.

Test Plan:
- Reset with RST_DIV=0, then write ch0 div=4 hi=0, en=1 -> clk_out[0] pattern 1100 repeating; tick[0] in every 4th cycle.
- ch1 div=5 hi=0 -> high 2 cycles, low 3 cycles. ch1 div=5 hi=9 -> high 4, low 1. ch1 div=1 -> clk_out[1] stays 0, no tick.
- ch0 running div=10, write div=4 at cnt=3 -> current 10-cycle period completes unchanged, next period is 4. cfg_ready for ch0 stays low until the cycle after the wrap.
- Back-to-back writes to the same channel -> second write stalls (ready=0) until the first is applied. A write to a different channel in the same window is accepted immediately.
- nrst pulsed low mid-period and asynchronously (not clock-aligned) -> all outputs 0 immediately, pending cleared. Restart matches fresh-reset behaviour.
- CLKDIV_SYNC_EN: ch0 div=6, ch2 div=3 free-running, pulse sync_in -> both clk_out rise on the same edge afterward. No tick for the truncated period.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the multi-channel clock/strobe divider.
// Fields are carried at DIV_W_MAX bits so that one helper serves any
// channel width up to 32 bits.
package clk_div_pkg;

  localparam int DIV_W_DEF = 24;
  localparam int DIV_W_MAX = 32;

  // One channel's period/high-time pair, zero-extended to DIV_W_MAX.
  typedef struct packed {
    logic [DIV_W_MAX-1:0] div;
    logic [DIV_W_MAX-1:0] hi;
  } chan_cfg_t;

  // Effective high time: 0 selects 50 % (the low phase takes the extra
  // cycle of an odd period). A high time of P or more is clamped to P-1,
  // so every running period keeps at least one low cycle.
  function automatic logic [DIV_W_MAX-1:0] eff_hi(
    input logic [DIV_W_MAX-1:0] div,
    input logic [DIV_W_MAX-1:0] hi
  );
    logic [DIV_W_MAX-1:0] res;
    if (hi == 32'd0) begin
      res = div >> 1;
    end else if (hi >= div) begin
      res = div - 32'd1;
    end else begin
      res = hi;
    end
    return res;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, shadow configuration with a
// pending flag, and the registered clk/tick outputs. New settings take
// effect only where a period starts: on the wrap edge, on a sync edge,
// or on the next edge while the channel is idle. Because of this the
// output never produces a runt pulse.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int RST_DIV = 0,
  parameter int RST_HI  = 0
) (
  input  logic             clk_in,
  input  logic             nrst,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             wr_i,
  input  logic [DIV_W-1:0] wr_div_i,
  input  logic [DIV_W-1:0] wr_hi_i,
  output logic             pend_o,
  output logic             clk_o,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] act_div_q, act_div_d;
  logic [DIV_W-1:0] act_hi_q, act_hi_d;
  logic [DIV_W-1:0] sh_div_q, sh_div_d;
  logic [DIV_W-1:0] sh_hi_q, sh_hi_d;
  logic             pend_q, pend_d;
  logic             run_q, run_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;

  logic             wrap_s;
  logic             apply_s;
  chan_cfg_t        nxt_cfg_s;
  logic [DIV_W_MAX-1:0] hi_eff_s;

  // Next-state logic. Outputs are computed from the next count and the
  // configuration in force for that count, so they line up with cnt_q.
  always_comb begin
    wrap_s  = run_q && (cnt_q == (act_div_q - DIV_W'(1)));
    // An idle channel (not running last cycle, or disabled now) picks up
    // its shadow on the next edge. A running one waits for the boundary.
    apply_s = pend_q && (wrap_s || sync_i || !run_q || !en_i);

    if (apply_s) begin
      act_div_d = sh_div_q;
      act_hi_d  = sh_hi_q;
    end else begin
      act_div_d = act_div_q;
      act_hi_d  = act_hi_q;
    end

    run_d = en_i && (act_div_d >= DIV_W'(2));

    if (!run_d) begin
      cnt_d = '0;
    end else if (!run_q || wrap_s || sync_i) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end

    nxt_cfg_s.div = DIV_W_MAX'(act_div_d);
    nxt_cfg_s.hi  = DIV_W_MAX'(act_hi_d);
    hi_eff_s      = eff_hi(nxt_cfg_s.div, nxt_cfg_s.hi);

    clk_d  = run_d && (DIV_W_MAX'(cnt_d) < hi_eff_s);
    tick_d = run_d && (cnt_d == (act_div_d - DIV_W'(1)));

    // The top level only writes when pend_q is clear, so a write and an
    // apply cannot occur in the same cycle.
    if (wr_i) begin
      pend_d   = 1'b1;
      sh_div_d = wr_div_i;
      sh_hi_d  = wr_hi_i;
    end else if (apply_s) begin
      pend_d   = 1'b0;
      sh_div_d = sh_div_q;
      sh_hi_d  = sh_hi_q;
    end else begin
      pend_d   = pend_q;
      sh_div_d = sh_div_q;
      sh_hi_d  = sh_hi_q;
    end
  end

  // Channel state registers. Reset clears everything, including pending
  // writes.
  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      cnt_q     <= '0;
      act_div_q <= DIV_W'(RST_DIV);
      act_hi_q  <= DIV_W'(RST_HI);
      sh_div_q  <= '0;
      sh_hi_q   <= '0;
      pend_q    <= 1'b0;
      run_q     <= 1'b0;
      clk_q     <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      act_div_q <= act_div_d;
      act_hi_q  <= act_hi_d;
      sh_div_q  <= sh_div_d;
      sh_hi_q   <= sh_hi_d;
      pend_q    <= pend_d;
      run_q     <= run_d;
      clk_q     <= clk_d;
      tick_q    <= tick_d;
    end
  end

  assign pend_o = pend_q;
  assign clk_o  = clk_q;
  assign tick_o = tick_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock/strobe divider top level.
// It holds the config decode and the ready mux. Each channel is a
// clk_div_chan instance.
// Optional build macro: CLKDIV_SYNC_EN adds sync_in. One high cycle of
// sync_in restarts every running channel at count 0 on the next edge.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int DIV_W   = DIV_W_DEF,
  parameter int RST_DIV = 0,
  parameter int RST_HI  = 0,
  localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk_in,
  input  logic             nrst,
  input  logic [NCH-1:0]   en,
`ifdef CLKDIV_SYNC_EN
  input  logic             sync_in,
`endif
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [DIV_W-1:0] cfg_hi,
  output logic [NCH-1:0]   clk_out,
  output logic [NCH-1:0]   tick
);

  // Every address cfg_ch can encode has a pending slot. Unpopulated slots
  // read as never pending, so out-of-range writes are accepted and then
  // discarded.
  localparam int NSLOT = 1 << CH_W;

  logic [NSLOT-1:0] pend_s;
  logic [NCH-1:0]   wr_s;
  logic             sync_s;

`ifdef CLKDIV_SYNC_EN
  assign sync_s = sync_in;
`else
  assign sync_s = 1'b0;
`endif

  assign cfg_ready = !pend_s[cfg_ch];

  // Route an accepted write to the addressed channel only.
  always_comb begin
    wr_s = '0;
    for (int i = 0; i < NCH; i++) begin
      if (cfg_valid && cfg_ready && (cfg_ch == CH_W'(i))) begin
        wr_s[i] = 1'b1;
      end else begin
        wr_s[i] = 1'b0;
      end
    end
  end

  generate
    if (NSLOT > NCH) begin : g_pad
      assign pend_s[NSLOT-1:NCH] = '0;
    end
  endgenerate

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    clk_div_chan #(
      .DIV_W   (DIV_W),
      .RST_DIV (RST_DIV),
      .RST_HI  (RST_HI)
    ) u_chan (
      .clk_in   (clk_in),
      .nrst     (nrst),
      .en_i     (en[g]),
      .sync_i   (sync_s),
      .wr_i     (wr_s[g]),
      .wr_div_i (cfg_div),
      .wr_hi_i  (cfg_hi),
      .pend_o   (pend_s[g]),
      .clk_o    (clk_out[g]),
      .tick_o   (tick[g])
    );
  end

endmodule
